dev_router: RTL

//  Parametrised successor of the two-target devctrl decode: routes one CPU device

---
 rtl/dev_router.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/dev_router.sv
// Address-decoding device router: steers one CPU device request to one of NUM_DEV
// slave channels, enforcing a minimum wait and a timeout, with bus-error reporting.

module dev_router_chk #(
  parameter int NUM_DEV  = 4,
  parameter int MIN_WAIT = 0,
  parameter int TIMEOUT  = 255
) (
  input logic               clk,
  input logic               rst,
  input logic [NUM_DEV-1:0] slv_enable
);

  // Configuration legality and one-hot channel select.
  always @(posedge clk) begin
    if (!rst) begin
      assert (TIMEOUT > MIN_WAIT);
      assert ($onehot0(slv_enable));
    end
  end

endmodule

module dev_router #(
  parameter int                        NUM_DEV   = 4,
  parameter int                        DATA_W    = 32,
  parameter int                        ADDR_W    = 32,
  parameter logic [NUM_DEV*ADDR_W-1:0] ADDR_BASE = '0,
  parameter logic [NUM_DEV*ADDR_W-1:0] ADDR_MASK = '0,
  parameter int                        MIN_WAIT  = 0,
  parameter int                        TIMEOUT   = 255,
  parameter logic [DATA_W-1:0]         ERR_DATA  = 32'hDEAD_BEEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      devEnable_i,
  input  logic                      devWrite_i,
  input  logic [ADDR_W-1:0]         devPhysicalAddr_i,
  input  logic [DATA_W/8-1:0]       devByteSelect_i,
  input  logic [DATA_W-1:0]         devDataSave_i,
  output logic [DATA_W-1:0]         devDataLoad_o,
  output logic                      devBusy_o,
  output logic [NUM_DEV-1:0]        slvEnable_o,
  output logic                      slvReadEnable_o,
  output logic [ADDR_W-1:0]         slvAddr_o,
  output logic [DATA_W/8-1:0]       slvByteSelect_o,
  output logic [DATA_W-1:0]         slvDataSave_o,
  input  logic [NUM_DEV*DATA_W-1:0] slvDataLoad_i,
  input  logic [NUM_DEV-1:0]        slvBusy_i,
  output logic                      busErr_o,
  output logic [ADDR_W-1:0]         errAddr_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam int IDX_W = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;

  localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_ERRW   = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  logic [1:0]         state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [IDX_W-1:0]   idx_r;
  logic [NUM_DEV-1:0] match_s;
  logic               hit_s;
  logic [IDX_W-1:0]   hit_idx_s;
  logic               sel_busy_s;
  logic [DATA_W-1:0]  sel_data_s;
  logic               min_ok_s;

  // Address decode; scanning downward lets the lowest matching channel win.
  always_comb begin
    match_s   = '0;
    hit_idx_s = '0;
    for (int i = NUM_DEV - 1; i >= 0; i--) begin
      match_s[i] = ((devPhysicalAddr_i & ADDR_MASK[i*ADDR_W +: ADDR_W]) == ADDR_BASE[i*ADDR_W +: ADDR_W]);
      hit_idx_s  = match_s[i] ? IDX_W'(i) : hit_idx_s;
    end
    hit_s = |match_s;
  end

  // Busy and load data of the channel owning the current access.
  always_comb begin
    sel_busy_s = 1'b0;
    sel_data_s = '0;
    for (int i = 0; i < NUM_DEV; i++) begin
      sel_busy_s = (idx_r == IDX_W'(i)) ? slvBusy_i[i] : sel_busy_s;
      sel_data_s = (idx_r == IDX_W'(i)) ? slvDataLoad_i[i*DATA_W +: DATA_W] : sel_data_s;
    end
  end

  if (MIN_WAIT == 0) begin : g_no_min
    assign min_ok_s = 1'b1;
  end else begin : g_min
    assign min_ok_s = (cnt_r >= CNT_W'(MIN_WAIT));
  end

  assign devBusy_o = ((state_r == ST_IDLE) & devEnable_i) | (state_r == ST_ACCESS) | (state_r == ST_ERRW);

  // Transaction sequencer; completion and timeout both pass through DONE so the CPU sees one uniform handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r         <= ST_IDLE;
      cnt_r           <= '0;
      idx_r           <= '0;
      slvEnable_o     <= '0;
      slvReadEnable_o <= 1'b1;
      slvAddr_o       <= '0;
      slvByteSelect_o <= '0;
      slvDataSave_o   <= '0;
      devDataLoad_o   <= '0;
      busErr_o        <= 1'b0;
      errAddr_o       <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          busErr_o <= 1'b0;
          if (devEnable_i && hit_s) begin
            slvAddr_o       <= devPhysicalAddr_i;
            slvByteSelect_o <= devByteSelect_i;
            slvDataSave_o   <= devDataSave_i;
            slvReadEnable_o <= ~devWrite_i;
            idx_r           <= hit_idx_s;
            slvEnable_o     <= NUM_DEV'(1'b1) << hit_idx_s;
            cnt_r           <= '0;
            state_r         <= ST_ACCESS;
          end else if (devEnable_i) begin
            errAddr_o <= devPhysicalAddr_i;
            state_r   <= ST_ERRW;
          end
        end
        ST_ACCESS: begin
          cnt_r <= (cnt_r != CNT_MAX) ? cnt_r + CNT_W'(1) : cnt_r;
          if (min_ok_s && !sel_busy_s) begin
            devDataLoad_o <= slvReadEnable_o ? sel_data_s : '0;
            slvEnable_o   <= '0;
            busErr_o      <= 1'b0;
            state_r       <= ST_DONE;
          end else if (cnt_r == CNT_TO) begin
            devDataLoad_o <= ERR_DATA;
            errAddr_o     <= slvAddr_o;
            slvEnable_o   <= '0;
            busErr_o      <= 1'b1;
            state_r       <= ST_DONE;
          end
        end
        ST_ERRW: begin
          devDataLoad_o <= ERR_DATA;
          busErr_o      <= 1'b1;
          state_r       <= ST_DONE;
        end
        ST_DONE: begin
          busErr_o <= 1'b0;
          state_r  <= ST_IDLE;
        end
        default: begin
          slvEnable_o <= '0;
          busErr_o    <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  dev_router_chk #(
    .NUM_DEV  (NUM_DEV),
    .MIN_WAIT (MIN_WAIT),
    .TIMEOUT  (TIMEOUT)
  ) u_chk (
    .clk        (clk),
    .rst        (rst),
    .slv_enable (slvEnable_o)
  );

endmodule
